// File: rtl/scramble_sequencer_pkg.sv
// Shared definitions for the scramble sequencer: FSM encodings, move direction
// codes, default LFSR seed and the maximal-length Galois tap table.
package scramble_sequencer_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAW  = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dirCodeT;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Right-shift Galois masks; bit k-1 set for each x^k term of the polynomial.
    function automatic logic [31:0] galoisTaps(input int width);
        logic [31:0] taps;
        case (width)
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0E08;
            13:      taps = 32'h0000_1C80;
            14:      taps = 32'h0000_3802;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0007_2000;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_D008;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/scramble_lfsr.sv
// Free-running maximal-length Galois LFSR; advances on every clock edge.
module scramble_lfsr
    import scramble_sequencer_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] TAPS    = WIDTH'(galoisTaps(WIDTH));
    // All-zero is the lock-up state of an XOR LFSR, so never start there.
    localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED_NZ;
        end else begin
            value <= (value >> 1) ^ (value[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/scramble_sequencer.sv
// Issues MOVE_COUNT pseudo-random board moves per button press, never
// immediately undoing the previous accepted move.
module scramble_sequencer
    import scramble_sequencer_pkg::*;
#(
    parameter int                    MOVE_COUNT = 31,
    parameter int                    DIR_WIDTH  = 2,
    parameter int                    LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_WIDTH'(DEFAULT_SEED),
    localparam int                   ML_W       = $clog2(MOVE_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 scramble_btn,
    input  logic                 mix_state,
    input  logic                 abort,
    input  logic                 move_ready,
    output logic                 move_valid,
    output logic [DIR_WIDTH-1:0] move_dir,
    output logic                 busy,
    output logic                 done,
    output logic [ML_W-1:0]      moves_left
);

    logic [1:0]            state;
    logic                  btnPrev;
    logic                  btnArmed;
    logic [DIR_WIDTH-1:0]  moveDir;
    logic [DIR_WIDTH-1:0]  lastDir;
    logic                  haveLast;
    logic [ML_W-1:0]       movesLeft;
    logic [LFSR_WIDTH-1:0] lfsrValue;
    logic [DIR_WIDTH-1:0]  cand;
    logic                  isInverse;
    logic                  start;
    logic                  unusedLfsrBits;

    scramble_lfsr #(
        .WIDTH (LFSR_WIDTH),
        .SEED  (SEED)
    ) uLfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsrValue)
    );

    assign cand           = lfsrValue[DIR_WIDTH-1:0];
    assign unusedLfsrBits = ^lfsrValue[LFSR_WIDTH-1:DIR_WIDTH];
    assign isInverse      = haveLast && (cand == (lastDir ^ DIR_WIDTH'(1)));

    // btnArmed stays low until the button has been seen released, so a press
    // held across reset release cannot masquerade as a fresh edge.
    assign start = (state == IDLE) && scramble_btn && !btnPrev && btnArmed
                   && !mix_state && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            btnPrev   <= 1'b0;
            btnArmed  <= 1'b0;
            moveDir   <= '0;
            lastDir   <= '0;
            haveLast  <= 1'b0;
            movesLeft <= '0;
        end else begin
            btnPrev  <= scramble_btn;
            btnArmed <= btnArmed | ~scramble_btn;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= DRAW;
                        movesLeft <= ML_W'(MOVE_COUNT);
                        haveLast  <= 1'b0;
                    end
                end
                DRAW: begin
                    if (abort) begin
                        state     <= IDLE;
                        movesLeft <= '0;
                    end else if (!isInverse) begin
                        moveDir <= cand;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Abort wins over a simultaneous handshake.
                    if (abort) begin
                        state     <= IDLE;
                        movesLeft <= '0;
                    end else if (move_ready) begin
                        movesLeft <= movesLeft - 1'b1;
                        lastDir   <= moveDir;
                        haveLast  <= 1'b1;
                        state     <= (movesLeft == ML_W'(1)) ? DONE : DRAW;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign move_valid = (state == ISSUE);
    assign move_dir   = moveDir;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign moves_left = movesLeft;

endmodule
